// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with mfhi/mflo/mthi/mtlo moves and a pipeline stall.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             issue,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             abort,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   raw_a;
    logic [2*WIDTH-1:0] acc;

    logic               is_md;
    logic               is_mv;
    logic               is_signed;
    logic               accept;
    logic               start;
    logic               finish_wr;
    logic               last_iter;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign is_md     = (func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign is_mv     = (func inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    assign is_signed = (func == F_MULT) || (func == F_DIV);
    assign sign_a    = is_signed & operand_a[WIDTH-1];
    assign sign_b    = is_signed & operand_b[WIDTH-1];
    assign mag_a     = sign_a ? -operand_a : operand_a;
    assign mag_b     = sign_b ? -operand_b : operand_b;
    assign stall     = issue & busy & (is_md | is_mv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        accept     = clk_en & issue & ~abort & (state == IDLE);
        start      = accept & is_md;
        finish_wr  = 1'b0;
        last_iter  = (cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_iter) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = IDLE;
                finish_wr  = ~abort;
            end
            default: next_state = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_add   = acc[0] ? opnd : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        mul_step  = {mul_sum, acc[WIDTH-1:1]};

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_step  = {div_rem, acc[WIDTH-2:0], div_ge};

        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

        if (div_zero) begin
            fin_hi = raw_a;
            fin_lo = '1;
        end else if (op_div) begin
            fin_hi = rem_fix;
            fin_lo = quo_fix;
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            raw_a    <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            result   <= '0;
            done     <= 1'b0;
            dbz      <= 1'b0;
        end else if (clk_en) begin
            done <= 1'b0;
            if (start) begin
                op_div   <= func[1];
                neg_q    <= sign_a ^ sign_b;
                neg_r    <= sign_a;
                div_zero <= func[1] & (operand_b == '0);
                raw_a    <= operand_a;
                opnd     <= func[1] ? mag_b : mag_a;
                acc      <= {{WIDTH{1'b0}}, (func[1] ? mag_a : mag_b)};
                cnt      <= '0;
                dbz      <= 1'b0;
            end else if (state == RUN) begin
                acc <= op_div ? div_step : mul_step;
                cnt <= last_iter ? '0 : cnt + 1'b1;
            end

            if (finish_wr) begin
                hi   <= fin_hi;
                lo   <= fin_lo;
                done <= 1'b1;
                dbz  <= div_zero;
            end

            if (accept && is_mv) begin
                case (func)
                    F_MFHI:  result <= hi;
                    F_MFLO:  result <= lo;
                    F_MTHI:  hi     <= operand_a;
                    F_MTLO:  lo     <= operand_a;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/dbz queued at issue, compared at done.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        issue;
    logic [5:0]  func;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        abort;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycles   = 0;
    int   busy_cnt = 0;
    int   t0       = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .issue     (issue),
        .func      (func),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .abort     (abort),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .dbz       (dbz),
        .hi        (hi),
        .lo        (lo),
        .result    (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      p;
        logic [63:0] up;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.hi  = '0;
        e.lo  = '0;
        e.dbz = 1'b0;
        case (f)
            6'd24: begin
                p    = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            6'd25: begin
                up   = {32'd0, x} * {32'd0, y};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    e.lo  = '1;
                    e.hi  = x;
                    e.dbz = 1'b1;
                end else if (f == 6'd26) begin
                    p    = sx / sy;
                    e.lo = p[31:0];
                    p    = sx % sy;
                    e.hi = p[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    task automatic cyc();
        if (busy) busy_cnt++;
        @(posedge clk);
        #1;
        cycles++;
    endtask

    task automatic start_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        func      = f;
        operand_a = x;
        operand_b = y;
        issue     = 1'b1;
        cyc();
        issue     = 1'b0;
        func      = 6'd32;
        if (f inside {6'd24, 6'd25, 6'd26, 6'd27}) begin
            sb.push_back(model(f, x, y));
            t0       = cycles;
            busy_cnt = 0;
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        exp_t e;
        int   guard;
        guard = 0;
        while (!done && guard < 200) begin
            cyc();
            guard++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            sb.delete();
            return;
        end
        check({tag, "_latency"}, 64'(cycles - t0), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_unexpected_done"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        check({tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
    endtask

    initial begin
        logic [31:0] r0;
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        int          seen;

        rst_n     = 1'b0;
        clk_en    = 1'b1;
        issue     = 1'b0;
        abort     = 1'b0;
        func      = 6'd32;
        operand_a = '0;
        operand_b = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        start_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_e0", 64'(busy), 64'd1);
        wait_done("multu_max", 33);
        check("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        start_op(6'd24, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg", 33);
        start_op(6'd18, 32'd0, 32'd0);
        check("mflo_after_mult", 64'(result), 64'h0000_0000_FFFF_FFF1);

        start_op(6'd26, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 33);
        start_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);

        start_op(6'd27, 32'd7, 32'd0);
        wait_done("divu_dbz", 33);
        check("divu_dbz_flag", 64'(dbz), 64'd1);
        start_op(6'd25, 32'd2, 32'd3);
        check("dbz_clear_on_accept", 64'(dbz), 64'd0);
        wait_done("multu_small", 33);

        start_op(6'd17, 32'h1234, 32'd0);
        check("mthi", 64'(hi), 64'h1234);
        r0 = result;
        start_op(6'd27, 32'd100, 32'd7);
        repeat (4) cyc();
        func  = 6'd18;
        issue = 1'b1;
        #1;
        check("stall_mflo_busy", 64'(stall), 64'd1);
        cyc();
        check("result_held_stall", 64'(result), 64'(r0));
        func = 6'd32;
        #1;
        check("no_stall_alu_op", 64'(stall), 64'd0);
        issue = 1'b0;
        wait_done("divu_hz", 33);
        start_op(6'd18, 32'd0, 32'd0);
        check("mflo_after_done", 64'(result), 64'd14);
        check("no_stall_idle", 64'(stall), 64'd0);
        start_op(6'd16, 32'd0, 32'd0);
        check("mfhi_after_done", 64'(result), 64'd2);

        start_op(6'd27, 32'd1000, 32'd3);
        repeat (9) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        sb.delete();
        check("abort_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            cyc();
            if (done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_hilo_hold", {hi, lo}, {32'd2, 32'd14});

        abort = 1'b1;
        start_op(6'd25, 32'd9, 32'd9);
        abort = 1'b0;
        sb.delete();
        check("abort_issue_rejected", 64'(busy), 64'd0);

        start_op(6'd25, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) cyc();
        clk_en = 1'b0;
        repeat (5) cyc();
        check("cen_hold_state", {62'd0, busy, done}, 64'd2);
        clk_en = 1'b1;
        wait_done("clk_en_hold", 38);

        for (int i = 0; i < 8; i++) begin
            f = 6'(24 + $urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i == 3) y = 32'd0;
            if (i == 5) y = $urandom_range(1, 15);
            start_op(f, x, y);
            wait_done("rnd", 33);
        end

        start_op(6'd25, 32'd77, 32'd88);
        repeat (10) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        #2;
        rst_n = 1'b1;
        sb.delete();
        cyc();
        check("post_rst_idle", {62'd0, busy, done}, 64'd0);
        start_op(6'd25, 32'd2, 32'd3);
        wait_done("post_rst_multu", 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
